round_robin_demux: RTL and testbench

Demultiplexer with valid/ready handshakes: the distributing counterpart of the 2:1 `mux` primitive used in the combinational exercises. It steers one upstream stream of `W`-bit words to one of `N` downstream lanes, either round-robin or by an explicit per-word select. Each lane has a one-entry output register. The block sits after a single producer and feeds `N` independent consumers, for example parallel workers in the sequential exercises.

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_lane_slot.sv | 48 ++++
 rtl/round_robin_demux.sv | 64 ++++++
 tb/tb_round_robin_demux.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and pointer-wrap helper for the round-robin demultiplexer.
package demux_pkg;

  localparam int DEMUX_N = 4;
  localparam int DEMUX_W = 8;

  // Round-robin successor: ptr+1, wrapping n-1 back to lane 0.
  function automatic int next_ptr(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage : demux_pkg

// File: rtl/demux_lane_slot.sv
// One-entry output register for a single downstream lane of the demux.
module demux_lane_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         take,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         can_load
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  // A full slot may still load when its consumer drains it in the same cycle.
  assign can_load = !valid_q || take;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (take) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      valid_q <= 1'b0;
      // NOTE: the data register is reset too because its value is visible on down_data after reset.
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule : demux_lane_slot

// File: rtl/round_robin_demux.sv
// Steers one valid/ready stream to N lanes, round-robin or by explicit select.
module round_robin_demux
  import demux_pkg::*;
#(
  parameter  int N  = DEMUX_N,
  parameter  int W  = DEMUX_W,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           up_valid,
  input  logic [W-1:0]   up_data,
  input  logic           up_sel_en,
  input  logic [SW-1:0]  up_sel,
  output logic           up_ready,
  output logic [N-1:0]   down_valid,
  output logic [N*W-1:0] down_data,
  input  logic [N-1:0]   down_ready
);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] tgt;
  logic          tgt_ok;
  logic          accept;
  logic [N-1:0]  lane_hit;
  logic [N-1:0]  lane_can_load;
  logic [N-1:0]  lane_load;

  // The pointed lane is never skipped: consumers count on word i landing in lane i mod N.
  always_comb begin
    tgt      = up_sel_en ? up_sel : ptr_q;
    tgt_ok   = !up_sel_en || (int'(up_sel) < N);
    lane_hit = '0;
    for (int k = 0; k < N; k++) begin
      lane_hit[k] = tgt_ok && (tgt == SW'(k));
    end
    up_ready  = |(lane_hit & lane_can_load);
    accept    = up_valid && up_ready;
    lane_load = up_valid ? (lane_hit & lane_can_load) : '0;
    ptr_d     = (accept && !up_sel_en) ? SW'(next_ptr(int'(ptr_q), N)) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    demux_lane_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (lane_load[k]),
      .load_data (up_data),
      .take      (down_ready[k]),
      .valid     (down_valid[k]),
      .data      (down_data[k*W +: W]),
      .can_load  (lane_can_load[k])
    );
  end

endmodule : round_robin_demux

// File: tb/tb_round_robin_demux.sv
// Directed self-checking bench for round_robin_demux (N=4 main instance, N=3 for invalid select).
module tb_round_robin_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_valid, up_sel_en, up_ready;
  logic [7:0]  up_data;
  logic [1:0]  up_sel;
  logic [3:0]  down_valid, down_ready;
  logic [31:0] down_data;

  logic        up_valid3, up_sel_en3, up_ready3;
  logic [7:0]  up_data3;
  logic [1:0]  up_sel3;
  logic [2:0]  down_valid3, down_ready3;
  logic [23:0] down_data3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  round_robin_demux #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data),
    .up_sel_en(up_sel_en), .up_sel(up_sel), .up_ready(up_ready),
    .down_valid(down_valid), .down_data(down_data), .down_ready(down_ready)
  );

  round_robin_demux #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .up_valid(up_valid3), .up_data(up_data3),
    .up_sel_en(up_sel_en3), .up_sel(up_sel3), .up_ready(up_ready3),
    .down_valid(down_valid3), .down_data(down_data3), .down_ready(down_ready3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lane(input logic [31:0] d, input int k);
    return d[k*8 +: 8];
  endfunction

  initial begin
    rst = 1'b1; up_valid = 0; up_data = 0; up_sel_en = 0; up_sel = 0; down_ready = 0;
    up_valid3 = 0; up_data3 = 0; up_sel_en3 = 0; up_sel3 = 0; down_ready3 = 0;
    step(); step();
    rst = 1'b0;
    #1;
    check("reset_valid", down_valid, 4'h0);
    check("reset_data", down_data, 32'h0);
    check("reset_ready", up_ready, 1'b1);

    // Back-to-back round robin with all consumers ready.
    down_ready = 4'hF;
    up_valid   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      up_data = 8'h10 + 8'(i);
      #1;
      check($sformatf("rr_ready_%0d", i), up_ready, 1'b1);
      step();
      check($sformatf("rr_valid_%0d", i), down_valid[i % 4], 1'b1);
      check($sformatf("rr_data_%0d", i), lane(down_data, i % 4), 8'h10 + 8'(i));
    end
    up_valid = 1'b0;
    step();
    check("rr_drained", down_valid, 4'h0);
    check("rr_hold_data", down_data, 32'h17161514);

    // Fill all lanes with consumers stalled; fifth word must wait for lane 0.
    down_ready = 4'h0;
    up_valid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_data = 8'hA0 + 8'(i);
      step();
      check($sformatf("fill_data_%0d", i), lane(down_data, i), 8'hA0 + 8'(i));
    end
    check("fill_valid", down_valid, 4'hF);
    up_data = 8'hA4;
    #1;
    check("stall_ready", up_ready, 1'b0);
    step();
    check("stall_lane0", lane(down_data, 0), 8'hA0);
    down_ready = 4'b0001;
    #1;
    check("drainfill_ready", up_ready, 1'b1);
    step();
    check("drainfill_data", lane(down_data, 0), 8'hA4);
    check("drainfill_valid", down_valid, 4'hF);
    up_valid = 1'b0;

    // Pointer is at lane 1; lane 1 stays full while the others drain.
    down_ready = 4'b1101;
    step();
    check("block_valid", down_valid, 4'b0010);
    down_ready = 4'h0;
    up_valid   = 1'b1;
    up_data    = 8'hB1;
    #1;
    check("block_ready", up_ready, 1'b0);
    step();
    check("block_hold", lane(down_data, 1), 8'hA1);
    down_ready = 4'b0010;
    #1;
    check("unblock_ready", up_ready, 1'b1);
    step();
    check("unblock_data", lane(down_data, 1), 8'hB1);
    up_valid = 1'b0;
    step();
    check("unblock_drained", down_valid, 4'h0);

    // Explicit select to lane 2 with consumer ready; pointer stays at 2.
    up_sel_en  = 1'b1;
    up_sel     = 2'd2;
    down_ready = 4'b0100;
    up_valid   = 1'b1;
    up_data    = 8'h55;
    step();
    check("sel_data0", lane(down_data, 2), 8'h55);
    check("sel_valid0", down_valid, 4'b0100);
    up_data = 8'h66;
    step();
    check("sel_data1", lane(down_data, 2), 8'h66);
    check("sel_valid1", down_valid, 4'b0100);
    up_valid = 1'b0;
    step();
    down_ready = 4'h0;
    up_sel_en  = 1'b0;
    up_valid   = 1'b1;
    up_data    = 8'hC2;
    step();
    check("ptr_kept_valid", down_valid, 4'b0100);
    check("ptr_kept_data", lane(down_data, 2), 8'hC2);
    up_valid = 1'b0;

    // Load lanes 0 and 3, then reset discards them and rewinds the pointer.
    down_ready = 4'b0100;
    up_sel_en  = 1'b1;
    up_valid   = 1'b1;
    up_sel     = 2'd0;
    up_data    = 8'hD0;
    step();
    down_ready = 4'h0;
    up_sel     = 2'd3;
    up_data    = 8'hD3;
    step();
    up_valid = 1'b0;
    check("pre_reset_valid", down_valid, 4'b1001);
    rst = 1'b1;
    step();
    rst       = 1'b0;
    up_sel_en = 1'b0;
    #1;
    check("midreset_valid", down_valid, 4'h0);
    check("midreset_data", down_data, 32'h0);
    check("midreset_ready", up_ready, 1'b1);
    up_valid = 1'b1;
    up_data  = 8'hE0;
    step();
    up_valid = 1'b0;
    check("midreset_ptr", down_valid, 4'b0001);
    check("midreset_ptr_data", lane(down_data, 0), 8'hE0);

    // N=3: select 3 is out of range and must never be accepted.
    up_sel_en3 = 1'b1;
    up_sel3    = 2'd3;
    up_valid3  = 1'b1;
    up_data3   = 8'h77;
    #1;
    check("inv_ready", up_ready3, 1'b0);
    step();
    check("inv_valid", down_valid3, 3'b000);
    up_sel3 = 2'd2;
    #1;
    check("n3_ready", up_ready3, 1'b1);
    step();
    up_valid3 = 1'b0;
    check("n3_valid", down_valid3, 3'b100);
    check("n3_data", down_data3[16 +: 8], 8'h77);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_round_robin_demux
